// File: rtl/ahb_mem_slv_if.sv
// AHB-Lite bus bundle for the memory slave: address/control/data from the
// master side, read data and response from the slave side.
interface ahb_mem_slv_if #(
    parameter int DW = 64
);
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic          HREADY;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADYOUT;
    logic          HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_mem_slv.sv
// AHB-Lite memory slave: byte-addressable RAM with optional wait states,
// two-cycle ERROR response for illegal transfers, and a write-only mailbox
// word that emits a one-cycle pulse carrying the low data byte.
module ahb_mem_slv #(
    parameter int          DW           = 64,
    parameter int          MEM_BYTES    = 65536,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          WAIT_STATES  = 0,
    parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ahb_mem_slv_if.slave  bus,
    output logic          mbox_wr,
    output logic [7:0]    mbox_data
);

    localparam int          BPW         = DW / 8;
    localparam int          OFFW        = $clog2(BPW);
    localparam int          WORDS       = MEM_BYTES / BPW;
    localparam int          IDXW        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] REGION_MASK = 32'(MEM_BYTES - 1);
    localparam logic [3:0]  WS          = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t state, state_nxt;

    // address-phase decode
    logic accept, accept_ok, acc_err, acc_mbox;
    logic in_region, size_bad, misaligned;
    logic [31:0] size_mask;

    // latched data-phase context
    logic        xfer_valid, xfer_write, xfer_mbox;
    logic [31:0] xfer_addr;
    logic [2:0]  xfer_size;
    logic [3:0]  wait_cnt;

    logic            complete, wr_now, rd_load, rd_mbox;
    logic [BPW-1:0]  strb;
    logic [31:0]     byte_lo, byte_span, rd_addr;
    logic [IDXW-1:0] wr_idx, rd_idx;
    logic [DW-1:0]   rd_word, hrdata;
    logic [DW-1:0]   mem [WORDS];

    // Word index within the region: offset modulo MEM_BYTES, then drop byte lanes.
    function automatic logic [IDXW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] w;
        w = (a & REGION_MASK) >> OFFW;
        return w[IDXW-1:0];
    endfunction

    // Decode the address phase; only IDLE/ERR2 have HREADYOUT high and may accept.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        in_region  = (bus.HADDR & ~REGION_MASK) == BASE_ADDR;
        acc_mbox   = bus.HADDR == MAILBOX_ADDR;
        size_bad   = bus.HSIZE > 3'(OFFW);
        size_mask  = (32'd1 << bus.HSIZE) - 32'd1;
        misaligned = (bus.HADDR & size_mask) != 32'd0;
        acc_err    = (!in_region && !acc_mbox) || size_bad || misaligned;
        accept     = bus.HSEL && bus.HREADY && bus.HTRANS[1] &&
                     (state == IDLE || state == ERR2);
        accept_ok  = accept && !acc_err;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ERR2: begin
                if (accept && acc_err)             state_nxt = ERR1;
                else if (accept && WS != 4'd0)     state_nxt = WAIT;
                else                               state_nxt = IDLE;
            end
            WAIT:    if (wait_cnt == 4'd1) state_nxt = IDLE;
            ERR1:    state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus response outputs, decoded from the state alone.
    always_comb begin
        bus.HREADYOUT = !(state == WAIT || state == ERR1);
        bus.HRESP     = (state == ERR1 || state == ERR2);
    end

    // Capture the accepted transfer and run the wait-state counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            xfer_valid <= 1'b0;
            xfer_write <= 1'b0;
            xfer_mbox  <= 1'b0;
            xfer_addr  <= '0;
            xfer_size  <= '0;
            wait_cnt   <= '0;
        end else begin
            // A high HREADYOUT ends the current data phase; the next one is whatever was accepted.
            if (bus.HREADYOUT) xfer_valid <= accept_ok;
            if (accept) begin
                xfer_write <= bus.HWRITE;
                xfer_mbox  <= acc_mbox;
                xfer_addr  <= bus.HADDR;
                xfer_size  <= bus.HSIZE;
            end
            if (accept_ok && WS != 4'd0) wait_cnt <= WS;
            else if (state == WAIT)      wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Final data-phase cycle of a legal transfer is IDLE with a pending transfer.
    assign complete = (state == IDLE) && xfer_valid;
    assign wr_now   = complete && xfer_write && !xfer_mbox;
    assign wr_idx   = word_idx(xfer_addr);

    // Byte-lane strobes from the latched size and low address bits.
    always_comb begin
        strb      = '0;
        byte_lo   = 32'(xfer_addr[OFFW-1:0]);
        byte_span = 32'd1 << xfer_size;
        for (int k = 0; k < BPW; k++)
            if (32'(k) >= byte_lo && 32'(k) < byte_lo + byte_span) strb[k] = 1'b1;
    end

    // Memory write of the enabled lanes at the end of a write's final data phase.
    // NOTE: the storage array has no reset; its contents survive HRESETn.
    always_ff @(posedge HCLK) begin
        if (wr_now)
            for (int k = 0; k < BPW; k++)
                if (strb[k]) mem[wr_idx][8*k +: 8] <= bus.HWDATA[8*k +: 8];
    end

    // Read word for the data phase about to start, forwarding a same-edge write.
    always_comb begin
        rd_addr = (state == WAIT) ? xfer_addr : bus.HADDR;
        rd_mbox = (state == WAIT) ? xfer_mbox : acc_mbox;
        rd_idx  = word_idx(rd_addr);
        rd_word = mem[rd_idx];
        for (int k = 0; k < BPW; k++)
            if (wr_now && wr_idx == rd_idx && strb[k])
                rd_word[8*k +: 8] = bus.HWDATA[8*k +: 8];
        if (rd_mbox) rd_word = '0;
    end

    // Load HRDATA on the edge that opens a read's final data phase.
    assign rd_load = (accept_ok && !bus.HWRITE && WS == 4'd0) ||
                     (state == WAIT && wait_cnt == 4'd1 && !xfer_write);

    // Read data register: holds its value through waits, errors and writes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     hrdata <= '0;
        else if (rd_load) hrdata <= rd_word;
    end

    assign bus.HRDATA = hrdata;

    // Mailbox pulse follows the completion edge of a mailbox write.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mbox_wr   <= 1'b0;
            mbox_data <= '0;
        end else begin
            mbox_wr <= complete && xfer_write && xfer_mbox;
            if (complete && xfer_write && xfer_mbox) mbox_data <= bus.HWDATA[7:0];
        end
    end

    // Burst type, protection and the SEQ/NONSEQ distinction do not affect this slave.
    logic unused_ok;
    assign unused_ok = ^{bus.HTRANS[0], bus.HBURST, bus.HPROT};

endmodule

// File: tb/tb_ahb_mem_slv.sv
// Directed bench: a zero-wait slave and a three-wait-state slave, each on its
// own bus, driven by a single-transfer task plus hand-built pipelined steps.
module tb_ahb_mem_slv;

    logic        hclk = 1'b0;
    logic        rst0_n, rst3_n;
    logic        mbox_wr0, mbox_wr3;
    logic [7:0]  mbox_data0, mbox_data3;
    int          errors = 0;
    int          checks = 0;

    localparam logic [31:0] MBOX = 32'hD058_0000;
    localparam logic [63:0] V1   = 64'h1122_3344_5566_7788;
    localparam logic [63:0] V2   = 64'hCAFE_F00D_0102_0304;
    localparam logic [63:0] V3   = 64'h0102_0304_0506_0708;
    localparam logic [63:0] V4   = 64'hA5A5_5A5A_0F0F_F0F0;

    always #5 hclk = ~hclk;

    ahb_mem_slv_if #(.DW(64)) b0 ();
    ahb_mem_slv_if #(.DW(64)) b3 ();

    // Single-slave systems: the bus HREADY is the slave's own HREADYOUT.
    assign b0.HREADY = b0.HREADYOUT;
    assign b3.HREADY = b3.HREADYOUT;

    ahb_mem_slv #(.DW(64), .WAIT_STATES(0)) u0 (
        .HCLK(hclk), .HRESETn(rst0_n), .bus(b0),
        .mbox_wr(mbox_wr0), .mbox_data(mbox_data0)
    );

    ahb_mem_slv #(.DW(64), .WAIT_STATES(3)) u3 (
        .HCLK(hclk), .HRESETn(rst3_n), .bus(b3),
        .mbox_wr(mbox_wr3), .mbox_data(mbox_data3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int d, input logic sel, input logic [1:0] tr,
                            input logic wr, input logic [31:0] a, input logic [2:0] sz);
        if (d == 0) begin
            b0.HSEL = sel; b0.HTRANS = tr; b0.HWRITE = wr; b0.HADDR = a; b0.HSIZE = sz;
        end else begin
            b3.HSEL = sel; b3.HTRANS = tr; b3.HWRITE = wr; b3.HADDR = a; b3.HSIZE = sz;
        end
    endtask

    task automatic set_wdata(input int d, input logic [63:0] w);
        if (d == 0) b0.HWDATA = w;
        else        b3.HWDATA = w;
    endtask

    function automatic logic rdy_of(input int d);
        return (d == 0) ? b0.HREADYOUT : b3.HREADYOUT;
    endfunction

    function automatic logic resp_of(input int d);
        return (d == 0) ? b0.HRESP : b3.HRESP;
    endfunction

    function automatic logic [63:0] rdata_of(input int d);
        return (d == 0) ? b0.HRDATA : b3.HRDATA;
    endfunction

    // One non-pipelined transfer; call just after a rising edge, returns just after one.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [63:0] wd, output logic [63:0] rd, output logic rsp,
                        output int waits, output logic err1);
        set_addr(d, 1'b1, 2'b10, wr, a, sz);
        @(posedge hclk); #1;
        set_addr(d, 1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        set_wdata(d, wd);
        waits = 0;
        err1  = 1'b0;
        @(negedge hclk);
        while (rdy_of(d) !== 1'b1 && waits < 32) begin
            if (resp_of(d) === 1'b1) err1 = 1'b1;
            waits++;
            @(negedge hclk);
        end
        check("ready_bound", 64'(waits < 32), 64'd1);
        rd  = rdata_of(d);
        rsp = resp_of(d);
        @(posedge hclk); #1;
    endtask

    initial begin
        logic [63:0] rd;
        logic        rsp, err1;
        int          waits;

        set_addr(0, 1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        set_addr(3, 1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        set_wdata(0, 64'h0);
        set_wdata(3, 64'h0);
        b0.HBURST = 3'd0; b0.HPROT = 4'd0;
        b3.HBURST = 3'd0; b3.HPROT = 4'd0;
        rst0_n = 1'b0;
        rst3_n = 1'b0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("rst_readyout", 64'(b0.HREADYOUT), 64'd1);
        check("rst_resp",     64'(b0.HRESP),     64'd0);
        check("rst_rdata",    b0.HRDATA,         64'd0);
        check("rst_mbox_wr",  64'(mbox_wr0),     64'd0);
        check("rst_mbox_dat", 64'(mbox_data0),   64'd0);
        @(posedge hclk); #1;
        rst0_n = 1'b1;
        rst3_n = 1'b1;

        // Zero-wait doubleword write and read.
        xfer(0, 1'b1, 32'h10, 3'd3, V1, rd, rsp, waits, err1);
        check("w64_waits", 64'(waits), 64'd0);
        check("w64_resp",  64'(rsp),   64'd0);
        xfer(0, 1'b0, 32'h10, 3'd3, 64'h0, rd, rsp, waits, err1);
        check("r64_waits", 64'(waits), 64'd0);
        check("r64_data",  rd,         V1);

        // Byte write into lane 3, junk on the other lanes.
        xfer(0, 1'b1, 32'h13, 3'd0, 64'hDEAD_BEEF_ABCC_DDEE, rd, rsp, waits, err1);
        check("wb_resp", 64'(rsp), 64'd0);
        xfer(0, 1'b0, 32'h10, 3'd3, 64'h0, rd, rsp, waits, err1);
        check("rb_data", rd, 64'h1122_3344_AB66_7788);

        // Halfword write into the top two lanes.
        xfer(0, 1'b1, 32'h16, 3'd1, 64'h1234_9999_9999_9999, rd, rsp, waits, err1);
        xfer(0, 1'b0, 32'h10, 3'd3, 64'h0, rd, rsp, waits, err1);
        check("rh_data", rd, 64'h1234_3344_AB66_7788);

        // Back-to-back write then read of the same word.
        set_addr(0, 1'b1, 2'b10, 1'b1, 32'h18, 3'd3);
        @(posedge hclk); #1;
        set_wdata(0, V2);
        set_addr(0, 1'b1, 2'b10, 1'b0, 32'h18, 3'd3);
        @(negedge hclk);
        check("b2b_w_ready", 64'(b0.HREADYOUT), 64'd1);
        @(posedge hclk); #1;
        set_addr(0, 1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        @(negedge hclk);
        check("b2b_r_ready", 64'(b0.HREADYOUT), 64'd1);
        check("b2b_r_data",  b0.HRDATA,         V2);
        @(posedge hclk); #1;

        // HRDATA holds across a write data phase.
        xfer(0, 1'b1, 32'h20, 3'd3, 64'h5555_5555_5555_5555, rd, rsp, waits, err1);
        check("hold_on_write", rd, V2);

        // Out-of-range read: ERR1 then ERR2, HRDATA held, then an OKAY read.
        xfer(0, 1'b0, 32'h0001_0000, 3'd3, 64'h0, rd, rsp, waits, err1);
        check("oor_err1",  64'(err1),  64'd1);
        check("oor_waits", 64'(waits), 64'd1);
        check("oor_err2",  64'(rsp),   64'd1);
        check("oor_hold",  rd,         V2);
        xfer(0, 1'b0, 32'h10, 3'd3, 64'h0, rd, rsp, waits, err1);
        check("after_err_resp", 64'(rsp), 64'd0);
        check("after_err_data", rd,       64'h1234_3344_AB66_7788);

        // Misaligned word and oversized transfers are errors.
        xfer(0, 1'b0, 32'h12, 3'd2, 64'h0, rd, rsp, waits, err1);
        check("misalign_resp", 64'(rsp), 64'd1);
        xfer(0, 1'b0, 32'h0, 3'd4, 64'h0, rd, rsp, waits, err1);
        check("oversize_resp", 64'(rsp), 64'd1);

        // Mailbox: pulse with the low byte, memory word 0 untouched, reads return 0.
        xfer(0, 1'b1, 32'h0, 3'd3, V3, rd, rsp, waits, err1);
        xfer(0, 1'b1, MBOX, 3'd2, 64'h7777_7777_7777_77FF, rd, rsp, waits, err1);
        check("mbox_resp",    64'(rsp),        64'd0);
        check("mbox_pulse",   64'(mbox_wr0),   64'd1);
        check("mbox_data",    64'(mbox_data0), 64'hFF);
        @(posedge hclk); #1;
        check("mbox_one_cyc", 64'(mbox_wr0),   64'd0);
        xfer(0, 1'b0, 32'h0, 3'd3, 64'h0, rd, rsp, waits, err1);
        check("mbox_mem_kept", rd, V3);
        xfer(0, 1'b0, MBOX, 3'd2, 64'h0, rd, rsp, waits, err1);
        check("mbox_rd_resp", 64'(rsp), 64'd0);
        check("mbox_rd_data", rd,       64'd0);

        // Three wait states: HREADYOUT low exactly three cycles, data on the fourth.
        xfer(3, 1'b1, 32'h40, 3'd3, V4, rd, rsp, waits, err1);
        check("ws3_w_waits", 64'(waits), 64'd3);
        check("ws3_w_resp",  64'(rsp),   64'd0);
        xfer(3, 1'b0, 32'h40, 3'd3, 64'h0, rd, rsp, waits, err1);
        check("ws3_r_waits", 64'(waits), 64'd3);
        check("ws3_r_data",  rd,         V4);

        // Reset during the WAIT of a write aborts it.
        set_addr(3, 1'b1, 2'b10, 1'b1, 32'h40, 3'd3);
        @(posedge hclk); #1;
        set_addr(3, 1'b0, 2'b00, 1'b0, 32'h0, 3'd0);
        set_wdata(3, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge hclk);
        check("abort_in_wait", 64'(b3.HREADYOUT), 64'd0);
        rst3_n = 1'b0;
        #1;
        check("abort_readyout", 64'(b3.HREADYOUT), 64'd1);
        check("abort_resp",     64'(b3.HRESP),     64'd0);
        check("abort_rdata",    b3.HRDATA,         64'd0);
        check("abort_mbox",     64'(mbox_wr3),     64'd0);
        @(posedge hclk); #1;
        rst3_n = 1'b1;
        xfer(3, 1'b0, 32'h40, 3'd3, 64'h0, rd, rsp, waits, err1);
        check("post_rst_waits", 64'(waits), 64'd3);
        check("post_rst_data",  rd,         V4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ahb_mem_slv.md
AHB_MEM_SLV -- requirements
Module: ahb_mem_slv

Interface
REQ-001 SHALL have parameter DW, default 64, meaning the data bus width (32 or 64 only).
REQ-002 SHALL have parameter MEM_BYTES, default 65536, meaning the memory size in bytes (power of two, at least DW/8).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the region base (aligned to MEM_BYTES).
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning the wait cycles inserted per OKAY transfer (0..15).
REQ-005 SHALL have parameter MAILBOX_ADDR, default 32'hD058_0000, meaning the mailbox word address.
REQ-006 SHALL have ports, clock and reset first:
- HCLK  in  1  clock.
- HRESETn  in  1  reset: asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  write when 1.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type, ignored.
- HPROT  in  4  protection, ignored.
- HREADY  in  1  bus ready.
- HWDATA  in  DW  write data.
- HRDATA  out  DW  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- mbox_wr  out  1  one-cycle mailbox write pulse.
- mbox_data  out  8  byte 0 of the mailbox write data.

Function
REQ-007 SHALL accept an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ or SEQ), latching HADDR, HWRITE and HSIZE.
REQ-008 SHALL answer IDLE/BUSY, and any cycle with HSEL=0, with HREADYOUT=1, HRESP=0 and no memory access.
REQ-009 SHALL flag an accepted transfer as an error when any of these holds:
- (HADDR & ~(MEM_BYTES-1)) != BASE_ADDR and HADDR != MAILBOX_ADDR;
- 2^HSIZE > DW/8;
- HADDR is not aligned to 2^HSIZE.
REQ-010 SHALL implement the FSM IDLE -> (WAIT | ERR1 | back-to-back data phase) with states IDLE, WAIT, ERR1, ERR2.
REQ-011 SHALL go to ERR1 on an accepted error transfer; ERR1 drives HREADYOUT=0, HRESP=1; ERR2 follows unconditionally and drives HREADYOUT=1, HRESP=1.
REQ-012 SHALL, for a legal transfer with WAIT_STATES=N>0, enter WAIT, load a counter with N, and drive HREADYOUT=0 for exactly N cycles, then HREADYOUT=1, HRESP=0.
REQ-013 SHALL complete a legal transfer with WAIT_STATES=0 in the cycle after the address phase with HREADYOUT=1 (zero-wait, pipelined).
REQ-014 SHALL accept a new address phase in the final data-phase cycle (HREADYOUT=1), including ERR2.
REQ-015 SHALL generate byte strobes from the latched HSIZE and the address low bits: byte k is enabled iff k is in [addr mod (DW/8), +2^HSIZE).
REQ-016 SHALL write the enabled HWDATA bytes to mem[(addr mod MEM_BYTES) aligned to DW/8] at the rising edge ending the final data-phase cycle of a legal write.
REQ-017 SHALL drive HRDATA with the full aligned word during the final data-phase cycle of a legal read.
REQ-018 SHALL return, for a read immediately after a write to the same word, the newly written data (write-then-read coherence).
REQ-019 SHALL hold HRDATA at its previous value during WAIT, ERR1, ERR2 and writes.
REQ-020 SHALL pulse mbox_wr for one cycle, with mbox_data = HWDATA[7:0], at completion of a write to MAILBOX_ADDR; mailbox writes SHALL NOT modify memory, and mailbox reads SHALL return 0 with OKAY.
REQ-021 SHALL allow BASE_ADDR regions that contain MAILBOX_ADDR; the mailbox takes priority.

Reset
REQ-022 SHALL, on HRESETn=0, asynchronously force: state IDLE, wait counter 0, HREADYOUT=1, HRESP=0, HRDATA=0, mbox_wr=0, mbox_data=0.
REQ-023 SHALL leave memory contents unchanged by reset.
REQ-024 SHALL abort any in-flight transfer (WAIT/ERR) when reset asserts mid-transfer, with no memory write.
REQ-025 SHALL accept a transfer on the first HCLK rising edge after HRESETn deasserts.

Verification
REQ-026 SHALL cover, with DW=64 and WS=0: word write 0x1122334455667788 to 0x10, then read 0x10 -> HRDATA=0x1122334455667788, HREADYOUT always 1.
REQ-027 SHALL cover a byte write 0xAB to 0x13 after REQ-026 -> readback 0x11223344AB667788.
REQ-028 SHALL cover WS=3: single read -> HREADYOUT low for exactly 3 cycles, data valid on the 4th data-phase cycle.
REQ-029 SHALL cover an out-of-range read at BASE_ADDR+MEM_BYTES -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); the next transfer returns OKAY.
REQ-030 SHALL cover a write of 0xFF to MAILBOX_ADDR -> mbox_wr pulses one cycle with mbox_data=0xFF, and memory is unchanged.
REQ-031 SHALL cover reset asserted during WAIT of a write -> outputs at reset values, and the target word keeps its old value.
